motor_step_gen: RTL

//  Downstream stage of the IR-sensor direction FSM: consumes its dir/en

---
 rtl/motor_step_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/motor_step_gen.sv
// motor_step_gen: STEP/DIR/ENA generator for a stepper driver.
// Trapezoidal speed profile, DIR-to-STEP setup delay, step counter.
//
// Ports:
//   CLK      system clock
//   RST      asynchronous, active-high reset
//   dir      requested direction (1=FW, 0=BW)
//   en       run request
//   STEP     registered step pulse
//   MOT_DIR  registered direction to driver
//   MOT_EN   registered driver enable
//   busy     high whenever the FSM is not idle
//   step_cnt steps issued since reset, wraps at 0xFFFF
module motor_step_gen #(
  parameter int CW        = 16,
  parameter int PER_MAX   = 1000,
  parameter int PER_MIN   = 200,
  parameter int PER_STEP  = 50,
  parameter int PULSE_W   = 10,
  parameter int SETUP_CYC = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dir,
  input  logic        en,
  output logic        STEP,
  output logic        MOT_DIR,
  output logic        MOT_EN,
  output logic        busy,
  output logic [15:0] step_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN_UP,
    S_CRUISE,
    S_RUN_DN
  } state_t;

  localparam logic [CW-1:0] PMAX_C  = CW'(PER_MAX);
  localparam logic [CW-1:0] PW_C    = CW'(PULSE_W);
  localparam logic [CW-1:0] SCYC_C  = CW'(SETUP_CYC);
  localparam logic [CW:0]   PMAX_W  = (CW+1)'(PER_MAX);
  localparam logic [CW:0]   PMIN_W  = (CW+1)'(PER_MIN);
  localparam logic [CW:0]   PSTEP_W = (CW+1)'(PER_STEP);

  state_t        state_q;
  logic [CW-1:0] period_q;
  logic [CW-1:0] pcnt_q;
  logic [CW-1:0] scnt_q;
  logic [15:0]   step_cnt_q;
  logic          step_q;
  logic          dir_q;
  logic          en_q;

  logic [CW:0]   per_slow_d;
  logic [CW:0]   per_fast_d;
  logic [CW-1:0] pcnt_nx_d;
  logic          per_end;
  logic          slow_stop;
  logic          stop_req;

  assign STEP     = step_q;
  assign MOT_DIR  = dir_q;
  assign MOT_EN   = en_q;
  assign step_cnt = step_cnt_q;
  assign busy     = (state_q != S_IDLE);

  // Ramp math is one bit wider than the period so neither
  // the add nor the subtract can wrap.
  assign per_slow_d = {1'b0, period_q} + PSTEP_W;
  assign per_fast_d =
    ({1'b0, period_q} >= (PMIN_W + PSTEP_W)) ?
    ({1'b0, period_q} - PSTEP_W) : PMIN_W;

  assign pcnt_nx_d = pcnt_q + 1'b1;
  assign per_end   = (pcnt_q == (period_q - 1'b1));
  assign slow_stop = (per_slow_d >= PMAX_W);
  assign stop_req  = !en || (dir != dir_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      period_q   <= PMAX_C;
      pcnt_q     <= '0;
      scnt_q     <= '0;
      step_cnt_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      en_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          step_q <= 1'b0;
          en_q   <= 1'b0;
          // Direction is only ever latched here, so the
          // driver never sees DIR move while enabled.
          if (en) begin
            dir_q   <= dir;
            en_q    <= 1'b1;
            scnt_q  <= SCYC_C - 1'b1;
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (!en) begin
            en_q    <= 1'b0;
            state_q <= S_IDLE;
          end else if (scnt_q == '0) begin
            // First step of the run rises on this edge.
            period_q   <= PMAX_C;
            pcnt_q     <= '0;
            step_q     <= 1'b1;
            step_cnt_q <= step_cnt_q + 16'd1;
            state_q    <= S_RUN_UP;
          end else begin
            scnt_q <= scnt_q - 1'b1;
          end
        end

        S_RUN_UP, S_CRUISE, S_RUN_DN: begin
          if (!per_end) begin
            pcnt_q <= pcnt_nx_d;
            step_q <= (pcnt_nx_d < PW_C);
          end else if ((state_q == S_RUN_DN) || stop_req) begin
            // Stop/reverse requests are only acted on at the
            // period boundary, so a step is never cut short.
            if (slow_stop) begin
              pcnt_q  <= '0;
              step_q  <= 1'b0;
              en_q    <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              period_q   <= per_slow_d[CW-1:0];
              pcnt_q     <= '0;
              step_q     <= 1'b1;
              step_cnt_q <= step_cnt_q + 16'd1;
              state_q    <= S_RUN_DN;
            end
          end else if (state_q == S_RUN_UP) begin
            period_q   <= per_fast_d[CW-1:0];
            pcnt_q     <= '0;
            step_q     <= 1'b1;
            step_cnt_q <= step_cnt_q + 16'd1;
            if (per_fast_d == PMIN_W) begin
              state_q <= S_CRUISE;
            end
          end else begin
            pcnt_q     <= '0;
            step_q     <= 1'b1;
            step_cnt_q <= step_cnt_q + 16'd1;
          end
        end

        default: begin
          step_q  <= 1'b0;
          en_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
